// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude-compare sequencer.
// Compares two WIDTH-bit unsigned operands by presenting one bit pair per cycle,
// MSB pair first, to an external combinational 2-bit comparator slice. The
// sequencer stops at the first unequal pair and reports a registered
// GT/EQ/LT/Err result together with a single-cycle done pulse.
module serial_cmp_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inStart,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [1:0]       outSliceA,
  output logic [1:0]       outSliceB,
  input  logic             inSliceGT,
  input  logic             inSliceEQ,
  input  logic             inSliceLT,
  output logic             outBusy,
  output logic             outDone,
  output logic             outGT,
  output logic             outEQ,
  output logic             outLT,
  output logic             outErr
);

  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [IW-1:0]    idx;

  logic accept;
  logic slice_ok;
  logic slice_last;
  logic slice_cont;

  // Handshake and slice-response decode
  always_comb begin
    accept     = (state == IDLE) && inStart;
    slice_ok   = $onehot({inSliceGT, inSliceEQ, inSliceLT});
    slice_last = (idx == '0);
    // Only a clean EQ on a non-final slice keeps the walk going
    slice_cont = slice_ok && inSliceEQ && !slice_last;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (inStart) begin
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (!slice_cont) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, slice index walk and result flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_a  <= '0;
      reg_b  <= '0;
      idx    <= '0;
      outGT  <= 1'b0;
      outEQ  <= 1'b0;
      outLT  <= 1'b0;
      outErr <= 1'b0;
    end else if (accept) begin
      reg_a  <= inA;
      reg_b  <= inB;
      idx    <= IDX_TOP;
      outGT  <= 1'b0;
      outEQ  <= 1'b0;
      outLT  <= 1'b0;
      outErr <= 1'b0;
    end else if (state == CMP) begin
      if (!slice_ok) begin
        outErr <= 1'b1;
      end else if (inSliceGT) begin
        outGT <= 1'b1;
      end else if (inSliceLT) begin
        outLT <= 1'b1;
      end else if (slice_last) begin
        outEQ <= 1'b1;
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

  // Bit-pair mux towards the comparator; quiet outside CMP
  always_comb begin
    outSliceA = '0;
    outSliceB = '0;
    if (state == CMP) begin
      for (int unsigned i = 0; i < NSLICE; i++) begin
        if (idx == IW'(i)) begin
          outSliceA = reg_a[2*i +: 2];
          outSliceB = reg_b[2*i +: 2];
        end
      end
    end
  end

  // Status decoded straight from the state register
  always_comb begin
    outBusy = (state == CMP);
    outDone = (state == DONE);
  end

endmodule
